stage_execute: RTL and testbench

//   Pipeline stage directly upstream of the writeback stage. Takes a decoded one-hot operation plus the cell

---
 rtl/stage_execute_pkg.sv | 39 +++
 rtl/stage_execute_alu.sv | 37 +++
 rtl/stage_execute.sv | 146 ++++++++++++++
 tb/tb_stage_execute.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_execute_pkg.sv
// ============================================================================
// Module  : stage_execute_pkg
// Brief   : Opcode bit indices, hazard predicates and FSM encodings shared by
//           the execute stage and its ALU.
// Revision: 1.0
// ============================================================================
`default_nettype none

package stage_execute_pkg;

    localparam int OP_PTR_INC = 0;
    localparam int OP_PTR_DEC = 1;
    localparam int OP_INC     = 2;
    localparam int OP_DEC     = 3;
    localparam int OP_OUT     = 4;
    localparam int OP_IN      = 5;
    localparam int OP_JZ      = 6;
    localparam int OP_JNZ     = 7;
    localparam int OPCODE_MSB = 7;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        IN_WAIT = 2'd1,
        IN_CAP  = 2'd2
    } ex_state_e;

    // Ops that change the cell value once they reach writeback.
    function automatic logic is_writer(input logic [OPCODE_MSB:0] op);
        return op[OP_INC] | op[OP_DEC] | op[OP_IN];
    endfunction

    // Ops whose result depends on the current cell value.
    function automatic logic is_reader(input logic [OPCODE_MSB:0] op);
        return op[OP_INC] | op[OP_DEC] | op[OP_OUT];
    endfunction

endpackage

`default_nettype wire

// File: rtl/stage_execute_alu.sv
// ============================================================================
// Module  : stage_execute_alu
// Brief   : Combinational result datapath: d, one-hot op, captured input byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stage_execute_alu
    import stage_execute_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic [D_WIDTH-1:0]  d,
    input  logic [OPCODE_MSB:0] op,
    input  logic [7:0]          cd,
    output logic [D_WIDTH-1:0]  result
);

    logic [D_WIDTH-1:0] cd_fit;

    // The input byte is zero-extended or truncated to the cell width.
    assign cd_fit = D_WIDTH'(cd);

    always_comb begin
        result = d;
        if (op[OP_INC]) begin
            result = d + D_WIDTH'(1);
        end else if (op[OP_DEC]) begin
            result = d - D_WIDTH'(1);
        end else if (op[OP_IN]) begin
            result = cd_fit;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stage_execute.sv
// ============================================================================
// Module  : stage_execute
// Brief   : Execute stage feeding writeback; IN handshake and RAW hazard
//           handling. Define STAGE_EXECUTE_FORWARD_EN to bypass instead of stall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stage_execute
    import stage_execute_pkg::*;
#(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [D_WIDTH-1:0]  d_in,
    input  logic [OPCODE_MSB:0] operation_in,
    output logic                ack,
    input  logic                ack_in,
    output logic [OPCODE_MSB:0] operation,
    output logic [D_WIDTH-1:0]  a,
    input  logic [7:0]          cd,
    input  logic                crda,
    output logic                cre
);

    ex_state_e           state_q, state_d;
    logic                cre_q, cre_d;
    logic [OPCODE_MSB:0] operation_q, operation_d;
    logic [D_WIDTH-1:0]  a_q, a_d;
    logic [7:0]          hold_q, hold_d;
    logic [D_WIDTH-1:0]  alu_d;
    logic [D_WIDTH-1:0]  result;
    logic [7:0]          in_byte;
    logic                in_op;
    logic                in_blocked;
    logic                stall;
    logic [A_WIDTH-1:0]  unused_a_width;

    assign unused_a_width = '0;
    assign in_op          = operation_in[OP_IN];
    assign in_blocked     = in_op && (state_q != IN_CAP);

    // The byte on cd is only valid while the strobe is out; afterwards use the copy.
    assign in_byte = cre_q ? cd : hold_q;
    assign hold_d  = in_byte;

`ifdef STAGE_EXECUTE_FORWARD_EN
    logic [D_WIDTH-1:0] fwd_q, fwd_d;

    assign stall = in_blocked;
    assign alu_d = is_writer(operation_q) ? fwd_q : d_in;
    assign fwd_d = (ack_in && !stall) ? result : fwd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_q <= '0;
        end else begin
            fwd_q <= fwd_d;
        end
    end
`else
    logic hazard;

    // One bubble lets writeback commit so d_in is current on the retry.
    assign hazard = is_writer(operation_q) && is_reader(operation_in);
    assign stall  = hazard || in_blocked;
    assign alu_d  = d_in;
`endif

    stage_execute_alu #(
        .D_WIDTH (D_WIDTH)
    ) u_alu (
        .d      (alu_d),
        .op     (operation_in),
        .cd     (in_byte),
        .result (result)
    );

    always_comb begin
        operation_d = operation_q;
        a_d         = a_q;
        if (ack_in) begin
            if (stall) begin
                operation_d = '0;
            end else begin
                operation_d = operation_in;
                a_d         = result;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cre_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (in_op) begin
                    if (crda) begin
                        cre_d   = 1'b1;
                        state_d = IN_CAP;
                    end else begin
                        state_d = IN_WAIT;
                    end
                end
            end
            IN_WAIT: begin
                if (crda) begin
                    cre_d   = 1'b1;
                    state_d = IN_CAP;
                end
            end
            IN_CAP: begin
                if (ack_in) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            cre_q       <= 1'b0;
            operation_q <= '0;
            a_q         <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            cre_q       <= cre_d;
            operation_q <= operation_d;
            a_q         <= a_d;
            hold_q      <= hold_d;
        end
    end

    assign ack       = ack_in && !stall;
    assign operation = operation_q;
    assign a         = a_q;
    assign cre       = cre_q;

endmodule

`default_nettype wire

// File: tb/tb_stage_execute.sv
// ============================================================================
// Module  : tb_stage_execute
// Brief   : Self-checking bench for stage_execute: vector table, directed
//           multi-cycle sequences and a randomized run against a cell model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stage_execute;
    import stage_execute_pkg::*;

    typedef logic [OPCODE_MSB:0] op_t;

    localparam op_t OPC_NONE = op_t'(0);
    localparam op_t OPC_INC  = op_t'(1 << OP_INC);
    localparam op_t OPC_DEC  = op_t'(1 << OP_DEC);
    localparam op_t OPC_OUT  = op_t'(1 << OP_OUT);
    localparam op_t OPC_IN   = op_t'(1 << OP_IN);
    localparam op_t OPC_PINC = op_t'(1 << OP_PTR_INC);
    localparam op_t OPC_PDEC = op_t'(1 << OP_PTR_DEC);
    localparam op_t OPC_JZ   = op_t'(1 << OP_JZ);
    localparam op_t OPC_JNZ  = op_t'(1 << OP_JNZ);

`ifdef STAGE_EXECUTE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d_in;
    op_t        operation_in;
    logic       ack;
    logic       ack_in;
    op_t        operation;
    logic [7:0] a;
    logic [7:0] cd;
    logic       crda;
    logic       cre;

    int checks = 0;
    int passes = 0;

    stage_execute #(
        .A_WIDTH (12),
        .D_WIDTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .d_in         (d_in),
        .operation_in (operation_in),
        .ack          (ack),
        .ack_in       (ack_in),
        .operation    (operation),
        .a            (a),
        .cd           (cd),
        .crda         (crda),
        .cre          (cre)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_t        op;
        logic [7:0] d;
        logic       ai;
        logic       e_ack;
        op_t        e_op;
        logic [7:0] e_a;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t op, input logic [7:0] d, input logic ai);
        operation_in = op;
        d_in         = d;
        ack_in       = ai;
    endtask

    function automatic logic m_writer(input op_t op);
        return (op == OPC_INC) || (op == OPC_DEC) || (op == OPC_IN);
    endfunction

    function automatic logic m_reader(input op_t op);
        return (op == OPC_INC) || (op == OPC_DEC) || (op == OPC_OUT);
    endfunction

    op_t        rops[8];
    op_t        m_op, r_op;
    logic [7:0] m_a, m_d, m_res, r_d;
    logic       r_ai, m_stall;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{OPC_INC,  8'hFF, 1'b1, 1'b1, OPC_INC,  8'h00};
        vecs[1] = '{OPC_DEC,  8'h00, 1'b1, 1'b1, OPC_DEC,  8'hFF};
        vecs[2] = '{OPC_INC,  8'h41, 1'b1, 1'b1, OPC_INC,  8'h42};
        vecs[3] = '{OPC_DEC,  8'h05, 1'b1, 1'b1, OPC_DEC,  8'h04};
        vecs[4] = '{OPC_OUT,  8'h7E, 1'b1, 1'b1, OPC_OUT,  8'h7E};
        vecs[5] = '{OPC_PINC, 8'h33, 1'b1, 1'b1, OPC_PINC, 8'h33};
        vecs[6] = '{OPC_NONE, 8'h99, 1'b1, 1'b1, OPC_NONE, 8'h99};
        vecs[7] = '{OPC_INC,  8'h10, 1'b0, 1'b0, OPC_NONE, 8'hAA};
        rops = '{OPC_NONE, OPC_INC, OPC_DEC, OPC_OUT, OPC_PINC, OPC_PDEC, OPC_JZ, OPC_JNZ};

        reset = 1'b0;
        drive(OPC_NONE, 8'h00, 1'b0);
        cd = 8'h00;
        crda = 1'b0;
        step();
        step();
        chk("reset_op", operation, 0);
        chk("reset_a", a, 0);
        chk("reset_cre", cre, 0);
        reset = 1'b1;
        step();

        // Vector table: each entry starts from a flushed pipe (op=0, a=AA).
        for (int i = 0; i < 8; i++) begin
            drive(OPC_NONE, 8'hAA, 1'b1);
            step();
            drive(vecs[i].op, vecs[i].d, vecs[i].ai);
            #1;
            chk($sformatf("vec%0d_ack", i), ack, vecs[i].e_ack);
            step();
            chk($sformatf("vec%0d_op", i), operation, vecs[i].e_op);
            chk($sformatf("vec%0d_a", i), a, vecs[i].e_a);
        end

        // DEC then OUT on the same cell.
        drive(OPC_NONE, 8'h05, 1'b1);
        step();
        drive(OPC_DEC, 8'h05, 1'b1);
        step();
        chk("decout_dec_a", a, 8'h04);
        drive(OPC_OUT, 8'h05, 1'b1);
        #1;
        chk("decout_ack", ack, FWD);
        step();
        if (!FWD) begin
            chk("decout_bubble_op", operation, 0);
            chk("decout_bubble_a", a, 8'h04);
            drive(OPC_OUT, 8'h04, 1'b1);
            #1;
            chk("decout_retry_ack", ack, 1);
            step();
        end
        chk("decout_out_op", operation, OPC_OUT);
        chk("decout_out_a", a, 8'h04);

        // ack_in low for 4 cycles with INC pending.
        drive(OPC_NONE, 8'h10, 1'b1);
        step();
        drive(OPC_INC, 8'h10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("hold%0d_ack", i), ack, 0);
            step();
            chk($sformatf("hold%0d_op", i), operation, 0);
            chk($sformatf("hold%0d_a", i), a, 8'h10);
        end
        ack_in = 1'b1;
        #1;
        chk("hold_rel_ack", ack, 1);
        step();
        chk("hold_rel_op", operation, OPC_INC);
        chk("hold_rel_a", a, 8'h11);
        drive(OPC_NONE, 8'h11, 1'b1);
        step();
        chk("hold_once_op", operation, 0);

        // IN with crda low for three cycles.
        drive(OPC_IN, 8'h00, 1'b1);
        crda = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("inwait%0d_ack", i), ack, 0);
            step();
            chk($sformatf("inwait%0d_op", i), operation, 0);
            chk($sformatf("inwait%0d_cre", i), cre, 0);
        end
        crda = 1'b1;
        step();
        chk("in_strobe_cre", cre, 1);
        chk("in_strobe_op", operation, 0);
        cd = 8'h41;
        #1;
        chk("in_cap_ack", ack, 1);
        step();
        chk("in_issue_op", operation, OPC_IN);
        chk("in_issue_a", a, 8'h41);
        chk("in_issue_cre", cre, 0);

        // A reader right behind IN is a hazard.
        drive(OPC_OUT, 8'h41, 1'b1);
        crda = 1'b0;
        cd = 8'h00;
        #1;
        chk("in_rd_ack", ack, FWD);
        step();
        if (!FWD) begin
            chk("in_rd_bubble", operation, 0);
            step();
        end
        chk("in_rd_op", operation, OPC_OUT);
        chk("in_rd_a", a, 8'h41);

        // IN captured while writeback is not accepting.
        drive(OPC_IN, 8'h00, 1'b0);
        crda = 1'b1;
        step();
        chk("incap_cre", cre, 1);
        cd = 8'h5A;
        step();
        cd = 8'h00;
        chk("incap_hold_cre", cre, 0);
        chk("incap_hold_op", operation, OPC_OUT);
        step();
        chk("incap_nostrobe", cre, 0);
        ack_in = 1'b1;
        #1;
        chk("incap_ack", ack, 1);
        step();
        chk("incap_op", operation, OPC_IN);
        chk("incap_a", a, 8'h5A);
        drive(OPC_NONE, 8'h00, 1'b1);
        crda = 1'b0;
        step();

        // Async reset while in IN_CAP.
        drive(OPC_INC, 8'h20, 1'b1);
        step();
        drive(OPC_IN, 8'h00, 1'b0);
        crda = 1'b1;
        step();
        chk("rstin_pre_cre", cre, 1);
        chk("rstin_pre_a", a, 8'h21);
        #2;
        reset = 1'b0;
        #1;
        chk("rstin_op", operation, 0);
        chk("rstin_a", a, 0);
        chk("rstin_cre", cre, 0);
        drive(OPC_NONE, 8'h00, 1'b1);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rstin_post%0d_cre", i), cre, 0);
            chk($sformatf("rstin_post%0d_op", i), operation, 0);
        end
        crda = 1'b0;

        // Bubble stream.
        for (int i = 0; i < 6; i++) begin
            drive(OPC_NONE, 8'($urandom), 1'($urandom_range(0, 1)));
            #1;
            chk($sformatf("bub%0d_ack", i), ack, ack_in);
            step();
            chk($sformatf("bub%0d_op", i), operation, 0);
            chk($sformatf("bub%0d_cre", i), cre, 0);
        end

        // Randomized run against a cell-level model.
        drive(OPC_NONE, 8'h00, 1'b1);
        step();
        m_op = OPC_NONE;
        m_a  = 8'h00;
        for (int i = 0; i < 300; i++) begin
            r_op = rops[$urandom_range(0, 7)];
            r_d  = 8'($urandom);
            r_ai = ($urandom_range(0, 3) != 0);
            drive(r_op, r_d, r_ai);
            m_stall = m_writer(m_op) && m_reader(r_op) && !FWD;
            m_d = (FWD && m_writer(m_op)) ? m_a : r_d;
            if (r_op == OPC_INC)      m_res = m_d + 8'd1;
            else if (r_op == OPC_DEC) m_res = m_d - 8'd1;
            else                      m_res = m_d;
            #1;
            chk($sformatf("rnd%0d_ack", i), ack, r_ai && !m_stall);
            if (r_ai) begin
                if (m_stall) begin
                    m_op = OPC_NONE;
                end else begin
                    m_op = r_op;
                    m_a  = m_res;
                end
            end
            step();
            chk($sformatf("rnd%0d_op", i), operation, m_op);
            chk($sformatf("rnd%0d_a", i), a, m_a);
            chk($sformatf("rnd%0d_cre", i), cre, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
